// File: rtl/key_entry_pkg.sv
// Shared types and limits for the keypad digit-entry buffer.
package key_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int BCD_MAX  = 9;
    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

endpackage

// File: rtl/bcd_time_check.sv
// Combinational legal-time test on a 4-digit BCD HH:MM value (d3 d2 : d1 d0).
module bcd_time_check
    import key_entry_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [4*DIGIT_W-1:0] digits_i,
    output logic                 legal_o
);

    logic [15:0] hour_w;
    logic [15:0] minute_w;

    always_comb begin
        hour_w   = 16'(digits_i[4*DIGIT_W-1 -: DIGIT_W]) * 16'd10
                 + 16'(digits_i[3*DIGIT_W-1 -: DIGIT_W]);
        minute_w = 16'(digits_i[2*DIGIT_W-1 -: DIGIT_W]) * 16'd10
                 + 16'(digits_i[DIGIT_W-1 -: DIGIT_W]);
        legal_o  = (hour_w <= 16'(MAX_HOUR)) && (minute_w <= 16'(MAX_MIN));
    end

endmodule

// File: rtl/key_entry_buffer.sv
// Keypad digit-entry buffer with backspace/clear, roll/lock overflow and a
// valid/ready commit hand-off. Define KEY_TIME_CHECK_EN to gate commits on a legal HH:MM.
module key_entry_buffer
    import key_entry_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = 4,
    parameter  int ROLL_MODE  = 1,
    localparam int BUF_W      = NUM_DIGITS * DIGIT_W,
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] key,
    input  logic               shift,
    input  logic               backspace,
    input  logic               clear,
    input  logic               commit,
    input  logic               commit_ready,
    output logic [BUF_W-1:0]   digits,
    output logic [CNT_W-1:0]   digit_count,
    output logic               full,
    output logic               key_err,
    output logic               commit_valid,
    output logic [BUF_W-1:0]   commit_data
);

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   digits_q, digits_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               key_err_q, key_err_d;
    logic               commit_valid_q, commit_valid_d;
    logic [BUF_W-1:0]   commit_data_q, commit_data_d;

    logic [BUF_W-1:0]   push_w;
    logic [BUF_W-1:0]   pop_w;
    logic               time_ok;

    // push_w: key enters slot 0, everything moves toward MS.
    // pop_w: everything moves toward LS, MS slot refills with 0.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        if (gi == 0) begin : g_ls
            assign push_w[gi*DIGIT_W +: DIGIT_W] = key;
        end else begin : g_up
            assign push_w[gi*DIGIT_W +: DIGIT_W] = digits_q[(gi-1)*DIGIT_W +: DIGIT_W];
        end
        if (gi == NUM_DIGITS - 1) begin : g_ms
            assign pop_w[gi*DIGIT_W +: DIGIT_W] = '0;
        end else begin : g_dn
            assign pop_w[gi*DIGIT_W +: DIGIT_W] = digits_q[(gi+1)*DIGIT_W +: DIGIT_W];
        end
    end

`ifdef KEY_TIME_CHECK_EN
    if (NUM_DIGITS != 4) begin : g_bad_width
        $error("key_entry_buffer: time check needs NUM_DIGITS == 4");
    end
    bcd_time_check #(.DIGIT_W(DIGIT_W)) u_time_check (
        .digits_i (digits_q[4*DIGIT_W-1:0]),
        .legal_o  (time_ok)
    );
`else
    assign time_ok = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        digits_d       = digits_q;
        count_d        = count_q;
        key_err_d      = 1'b0;
        commit_valid_d = commit_valid_q;
        commit_data_d  = commit_data_q;

        if (state_q == ST_COMMIT) begin
            // The buffer is frozen; any strobe here is a user error.
            key_err_d = clear | backspace | shift | commit;
            if (commit_valid_q && commit_ready) begin
                commit_valid_d = 1'b0;
                digits_d       = '0;
                count_d        = '0;
            end
        end else if (clear) begin
            digits_d = '0;
            count_d  = '0;
        end else if (backspace) begin
            if (count_q != '0) begin
                digits_d = pop_w;
                count_d  = count_q - CNT_W'(1);
            end else begin
                key_err_d = 1'b1;
            end
        end else if (shift) begin
            if (int'(key) > BCD_MAX) begin
                key_err_d = 1'b1;
            end else if (!full_q) begin
                digits_d = push_w;
                count_d  = count_q + CNT_W'(1);
            end else if (ROLL_MODE != 0) begin
                digits_d = push_w;
            end else begin
                key_err_d = 1'b1;
            end
        end else if (commit) begin
            if (state_q == ST_IDLE || !time_ok) begin
                key_err_d = 1'b1;
            end else begin
                commit_data_d  = digits_q;
                commit_valid_d = 1'b1;
            end
        end

        if (commit_valid_d) begin
            state_d = ST_COMMIT;
        end else if (count_d == '0) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_ENTRY;
        end
        full_d = (count_d == CNT_W'(NUM_DIGITS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            digits_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            key_err_q      <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            digits_q       <= digits_d;
            count_q        <= count_d;
            full_q         <= full_d;
            key_err_q      <= key_err_d;
            commit_valid_q <= commit_valid_d;
            commit_data_q  <= commit_data_d;
        end
    end

    assign digits       = digits_q;
    assign digit_count  = count_q;
    assign full         = full_q;
    assign key_err      = key_err_q;
    assign commit_valid = commit_valid_q;
    assign commit_data  = commit_data_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: roll (index 0) and lock (index 1) instances share
// stimulus and are checked against an arithmetic model of the entered number.
module tb_key_entry_buffer;

    localparam longint BASE = 16;
    localparam longint MODV = 65536;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key;
    logic        shift, backspace, clear, commit, commit_ready;

    logic [15:0] dig_o [2];
    logic [2:0]  cnt_o [2];
    logic        full_o [2];
    logic        err_o [2];
    logic        cv_o [2];
    logic [15:0] cd_o [2];

    int checks = 0;
    int errors = 0;
    int txn = 0;

    longint mval [2];
    longint msnap [2];
    int     mcnt [2];
    bit     mcom [2];
    bit     merr [2];

    always #5 clk = ~clk;

    key_entry_buffer #(.NUM_DIGITS(4), .DIGIT_W(4), .ROLL_MODE(1)) dut_roll (
        .clk(clk), .reset(reset), .key(key), .shift(shift), .backspace(backspace),
        .clear(clear), .commit(commit), .commit_ready(commit_ready),
        .digits(dig_o[0]), .digit_count(cnt_o[0]), .full(full_o[0]), .key_err(err_o[0]),
        .commit_valid(cv_o[0]), .commit_data(cd_o[0])
    );

    key_entry_buffer #(.NUM_DIGITS(4), .DIGIT_W(4), .ROLL_MODE(0)) dut_lock (
        .clk(clk), .reset(reset), .key(key), .shift(shift), .backspace(backspace),
        .clear(clear), .commit(commit), .commit_ready(commit_ready),
        .digits(dig_o[1]), .digit_count(cnt_o[1]), .full(full_o[1]), .key_err(err_o[1]),
        .commit_valid(cv_o[1]), .commit_data(cd_o[1])
    );

    function automatic bit legal_time(input longint v);
`ifdef KEY_TIME_CHECK_EN
        longint hr, mn;
        hr = ((v >> 12) % 16) * 10 + ((v >> 8) % 16);
        mn = ((v >> 4) % 16) * 10 + (v % 16);
        return (hr <= 23) && (mn <= 59);
`else
        return v >= 0;
`endif
    endfunction

    // Model: the buffer is a number in base 16 holding mcnt digits.
    task automatic model_step(input int m, input bit clr, bs, sh, cm, input int k, input bit rdy);
        merr[m] = 1'b0;
        if (mcom[m]) begin
            merr[m] = clr | bs | sh | cm;
            if (rdy) begin
                mval[m] = 0; mcnt[m] = 0; mcom[m] = 1'b0;
            end
        end else if (clr) begin
            mval[m] = 0; mcnt[m] = 0;
        end else if (bs) begin
            if (mcnt[m] > 0) begin mval[m] = mval[m] / BASE; mcnt[m]--; end
            else merr[m] = 1'b1;
        end else if (sh) begin
            if (k > 9) merr[m] = 1'b1;
            else if (mcnt[m] < 4) begin mval[m] = (mval[m] * BASE + k) % MODV; mcnt[m]++; end
            else if (m == 0) mval[m] = (mval[m] * BASE + k) % MODV;
            else merr[m] = 1'b1;
        end else if (cm) begin
            if (mcnt[m] == 0 || !legal_time(mval[m])) merr[m] = 1'b1;
            else begin msnap[m] = mval[m]; mcom[m] = 1'b1; end
        end
    endtask

    task automatic cycle(input bit clr, bs, sh, cm, input int k, input bit rdy);
        clear = clr; backspace = bs; shift = sh; commit = cm; key = 4'(k); commit_ready = rdy;
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m, clr, bs, sh, cm, k, rdy);
        @(negedge clk);
        clear = 1'b0; backspace = 1'b0; shift = 1'b0; commit = 1'b0;
        txn++;
        $display("txn %0d clr=%0b bs=%0b sh=%0b cm=%0b key=%h rdy=%0b | roll d=%h c=%0d e=%0b v=%0b | lock d=%h c=%0d e=%0b v=%0b",
                 txn, clr, bs, sh, cm, key, rdy, dig_o[0], cnt_o[0], err_o[0], cv_o[0],
                 dig_o[1], cnt_o[1], err_o[1], cv_o[1]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            mval[m] = 0; msnap[m] = 0; mcnt[m] = 0; mcom[m] = 1'b0; merr[m] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({dig_o[m], cnt_o[m], full_o[m], err_o[m], cv_o[m], cd_o[m]} !== 38'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got d=%h c=%0d f=%0b e=%0b v=%0b cd=%h, want all 0",
                         m, dig_o[m], cnt_o[m], full_o[m], err_o[m], cv_o[m], cd_o[m]);
            end
        end
    endtask

    task automatic test_entry_and_roll();
        cycle(0, 0, 1, 0, 1, 0);
        cycle(0, 0, 1, 0, 2, 0);
        cycle(0, 0, 1, 0, 3, 0);
        cycle(0, 0, 1, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({dig_o[m], cnt_o[m], full_o[m], err_o[m]} !== {16'h1230, 3'd4, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL entry_1230[%0d]: got d=%h c=%0d f=%0b e=%0b, want 1230 4 1 0",
                         m, dig_o[m], cnt_o[m], full_o[m], err_o[m]);
            end
        end
        cycle(0, 0, 1, 0, 5, 0);
        checks++;
        if ({dig_o[0], cnt_o[0], err_o[0]} !== {16'h2305, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL roll_full: got d=%h c=%0d e=%0b, want 2305 4 0", dig_o[0], cnt_o[0], err_o[0]);
        end
        checks++;
        if ({dig_o[1], cnt_o[1], err_o[1]} !== {16'h1230, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL lock_full: got d=%h c=%0d e=%0b, want 1230 4 1", dig_o[1], cnt_o[1], err_o[1]);
        end
        cycle(0, 0, 0, 0, 0, 0);
        checks++;
        if (err_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL lock_err_pulse: got key_err=%0b, want 0 one cycle later", err_o[1]);
        end
    endtask

    task automatic test_backspace_clear();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1, 0);
        cycle(0, 0, 1, 0, 2, 0);
        cycle(0, 0, 1, 0, 3, 0);
        cycle(0, 1, 0, 0, 0, 0);
        checks++;
        if ({dig_o[0], cnt_o[0], err_o[0]} !== {16'h0012, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL backspace: got d=%h c=%0d e=%0b, want 0012 2 0", dig_o[0], cnt_o[0], err_o[0]);
        end
        cycle(1, 0, 1, 0, 7, 0);
        checks++;
        if ({dig_o[0], cnt_o[0], full_o[0], err_o[0]} !== {16'h0000, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear_over_shift: got d=%h c=%0d e=%0b, want 0 0 0", dig_o[0], cnt_o[0], err_o[0]);
        end
        cycle(0, 1, 0, 0, 0, 0);
        checks++;
        if ({dig_o[0], cnt_o[0], err_o[0]} !== {16'h0000, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL backspace_empty: got d=%h c=%0d e=%0b, want 0 0 1", dig_o[0], cnt_o[0], err_o[0]);
        end
    endtask

    task automatic test_errors();
        cycle(0, 0, 1, 0, 10, 0);
        checks++;
        if ({dig_o[0], cnt_o[0], err_o[0]} !== {16'h0000, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL bad_key: got d=%h c=%0d e=%0b, want 0 0 1", dig_o[0], cnt_o[0], err_o[0]);
        end
        cycle(0, 0, 0, 1, 0, 1);
        checks++;
        if ({err_o[0], cv_o[0]} !== 2'b10) begin
            errors++;
            $display("FAIL commit_idle: got e=%0b v=%0b, want e=1 v=0", err_o[0], cv_o[0]);
        end
    endtask

    task automatic test_commit_wait();
        cycle(0, 0, 1, 0, 7, 0);
        cycle(0, 0, 1, 0, 4, 0);
        cycle(0, 0, 1, 0, 5, 0);
        cycle(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({cv_o[0], cd_o[0], dig_o[0], cnt_o[0]} !== {1'b1, 16'h0745, 16'h0745, 3'd3}) begin
                errors++;
                $display("FAIL commit_hold[%0d]: got v=%0b cd=%h d=%h c=%0d, want 1 0745 0745 3",
                         i, cv_o[0], cd_o[0], dig_o[0], cnt_o[0]);
            end
            cycle(0, 0, i == 2, 0, 9, 0);
            checks++;
            if (err_o[0] !== (i == 2)) begin
                errors++;
                $display("FAIL commit_strobe_err[%0d]: got key_err=%0b, want %0b", i, err_o[0], i == 2);
            end
        end
        cycle(0, 0, 0, 0, 0, 1);
        checks++;
        if ({cv_o[0], dig_o[0], cnt_o[0], full_o[0]} !== {1'b0, 16'h0000, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL handshake: got v=%0b d=%h c=%0d, want 0 0 0", cv_o[0], dig_o[0], cnt_o[0]);
        end
    endtask

    task automatic test_time_check();
`ifdef KEY_TIME_CHECK_EN
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 2, 0); cycle(0, 0, 1, 0, 4, 0);
        cycle(0, 0, 1, 0, 6, 0); cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        checks++;
        if ({err_o[0], cv_o[0], cnt_o[0]} !== {1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL time_2460: got e=%0b v=%0b c=%0d, want 1 0 4", err_o[0], cv_o[0], cnt_o[0]);
        end
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 2, 0); cycle(0, 0, 1, 0, 3, 0);
        cycle(0, 0, 1, 0, 5, 0); cycle(0, 0, 1, 0, 9, 0);
        cycle(0, 0, 0, 1, 0, 0);
        checks++;
        if ({err_o[0], cv_o[0], cd_o[0]} !== {1'b0, 1'b1, 16'h2359}) begin
            errors++;
            $display("FAIL time_2359: got e=%0b v=%0b cd=%h, want 0 1 2359", err_o[0], cv_o[0], cd_o[0]);
        end
        cycle(0, 0, 0, 0, 0, 1);
`endif
    endtask

    task automatic test_reset_in_commit();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1, 0);
        cycle(0, 0, 1, 0, 2, 0);
        cycle(0, 0, 0, 1, 0, 0);
        checks++;
        if ({cv_o[0], cd_o[0]} !== {1'b1, 16'h0012}) begin
            errors++;
            $display("FAIL pre_reset_commit: got v=%0b cd=%h, want 1 0012", cv_o[0], cd_o[0]);
        end
        do_reset();
        checks++;
        if ({dig_o[0], cnt_o[0], full_o[0], err_o[0], cv_o[0], cd_o[0]} !== 38'd0) begin
            errors++;
            $display("FAIL reset_in_commit: got d=%h c=%0d v=%0b cd=%h, want all 0",
                     dig_o[0], cnt_o[0], cv_o[0], cd_o[0]);
        end
    endtask

    task automatic test_random();
        bit clr, bs, sh, cm, rdy;
        int k;
        for (int n = 0; n < 400; n++) begin
            clr = ($urandom % 16) == 0;
            bs  = ($urandom % 6) == 0;
            sh  = ($urandom % 2) == 0;
            cm  = ($urandom % 5) == 0;
            rdy = ($urandom % 3) == 0;
            k   = (($urandom % 5) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            cycle(clr, bs, sh, cm, k, rdy);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if ({dig_o[m], cnt_o[m], full_o[m], err_o[m], cv_o[m]} !==
                    {mval[m][15:0], 3'(mcnt[m]), mcnt[m] == 4, merr[m], mcom[m]}) begin
                    errors++;
                    $display("FAIL random[%0d] n=%0d: got d=%h c=%0d f=%0b e=%0b v=%0b, want d=%h c=%0d e=%0b v=%0b",
                             m, n, dig_o[m], cnt_o[m], full_o[m], err_o[m], cv_o[m],
                             mval[m][15:0], mcnt[m], merr[m], mcom[m]);
                end
                if (mcom[m]) begin
                    checks++;
                    if (cd_o[m] !== msnap[m][15:0]) begin
                        errors++;
                        $display("FAIL random_cdata[%0d] n=%0d: got %h, want %h", m, n, cd_o[m], msnap[m][15:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; key = 4'd0; shift = 1'b0; backspace = 1'b0;
        clear = 1'b0; commit = 1'b0; commit_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_entry_and_roll();
        test_backspace_clear();
        test_errors();
        test_commit_wait();
        test_time_check();
        test_reset_in_commit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_entry_buffer.md
Name: key_entry_buffer

Overview:
Parametrised keypad digit-entry buffer; next generation of the alarm-clock key shift register. Accepts BCD digits from the keypad decoder and shifts them in at the least-significant position. Adds:
- digit validation
- backspace and clear
- selectable roll/lock overflow
- a valid/ready commit handshake that hands the assembled value to the time/alarm registers.

Parameters:
NUM_DIGITS, 4, number of digit slots in the buffer (≥2).
DIGIT_W, 4, bits per digit; digits are BCD, so legal values are 0–9.
ROLL_MODE, 1, 1 = a key when full drops the MS digit and shifts; 0 = a key when full is rejected.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
key  in  DIGIT_W  digit code from the keypad decoder
shift  in  1  one-cycle strobe: key is valid this cycle
backspace  in  1  one-cycle strobe: remove the LS digit
clear  in  1  one-cycle strobe: empty the buffer
commit  in  1  one-cycle strobe: request hand-off of the buffer
commit_ready  in  1  downstream accepts commit_data
digits  out  NUM_DIGITS*DIGIT_W  live buffer; digit 0 = bits [DIGIT_W-1:0] = LS
digit_count  out  $clog2(NUM_DIGITS+1)  number of digits entered
full  out  1  digit_count == NUM_DIGITS
key_err  out  1  one-cycle pulse on any rejected request
commit_valid  out  1  commit_data is valid; held until the handshake
commit_data  out  NUM_DIGITS*DIGIT_W  snapshot taken at commit

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE. Reset mid-commit drops commit_valid on the next edge; no handshake is completed.
- State machine: IDLE (count 0), ENTRY (0 < count), COMMIT.
- Request priority within a cycle: clear > backspace > shift > commit. Only the highest-priority asserted strobe acts; lower ones are silently dropped, with no key_err.
- shift, not full:
  - digits shift one slot toward MS; key loads into digit 0; count++.
  - All outputs update on the following edge (1-cycle latency).
- shift, full:
  - ROLL_MODE=1: MS digit discarded, shift as above, count unchanged.
  - ROLL_MODE=0: buffer unchanged; key_err pulses.
- shift with key > 9: buffer unchanged; key_err pulses.
- backspace:
  - count > 0: digits shift one slot toward LS, MS slot loads 0, count--.
  - count == 0: no change; key_err pulses.
- clear: digits and count become 0; state IDLE. Never an error outside COMMIT.
- commit:
  - State ENTRY: commit_data captures digits and commit_valid rises on the next edge; state COMMIT.
  - State IDLE: key_err pulses; state stays IDLE.
- State COMMIT:
  - shift, backspace, clear and commit are ignored, except that each asserted strobe pulses key_err.
  - commit_data is stable while commit_valid is high.
  - On the cycle commit_valid & commit_ready: the next edge drops commit_valid, zeroes digits and count, and moves to IDLE.
  - commit_ready may be high continuously; the minimum COMMIT residency is 1 cycle.
- State transitions after an update: count reaching 0 → IDLE; count > 0 → ENTRY.
- full and digit_count are registered, consistent with digits.

Optional Feature:
Macro: KEY_TIME_CHECK_EN.
- Defined:
  - NUM_DIGITS must be 4; any other value causes an elaboration $error.
  - A commit is accepted only if the HH:MM value is a legal time: hr = d3*10+d2 ≤ 23 and min = d1*10+d0 ≤ 59.
  - If the value is illegal, key_err pulses and the state stays ENTRY.
- Undefined: no range check; any nonzero count commits.

Decomposition:
Shared package key_entry_pkg holds:
- the state enum type (IDLE/ENTRY/COMMIT)
- BCD_MAX = 9
- MAX_HOUR = 23 and MAX_MIN = 59

One sub-module, bcd_time_check, is natural: combinational 4-digit legal-time test, instantiated only under KEY_TIME_CHECK_EN.

Test Plan:
1. Reset, then shift keys 1,2,3,0 → digits=16'h1230, count=4, full=1, state ENTRY.
2. ROLL_MODE=1, full with 1230, shift key 5 → digits=16'h2305, count 4. ROLL_MODE=0, same stimulus → digits remain 16'h1230; key_err for 1 cycle.
3. Buffer 0x0123 (count 3):
   - backspace → digits=16'h0012, count 2.
   - clear and shift asserted in the same cycle → digits=0, count=0, state IDLE, no key_err.
   - backspace while empty → key_err.
4. Shift key 4'hA → key_err for 1 cycle, buffer unchanged. Commit in IDLE → key_err, commit_valid stays 0.
5. Buffer 16'h0745, commit with commit_ready=0 for 5 cycles:
   - commit_valid=1 and commit_data=16'h0745 stable throughout.
   - shift key 9 during the wait → key_err; buffer unchanged.
   - then commit_ready=1 → next edge commit_valid=0, digits=0, state IDLE.
6. KEY_TIME_CHECK_EN defined:
   - commit on 16'h2460 → key_err, state stays ENTRY.
   - commit on 16'h2359 → commit_valid=1, commit_data=16'h2359.
   - assert reset while in COMMIT → commit_valid=0 and all outputs 0 on the next edge.
